instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential fetch controller between the core's decode stage and the combinational, byte-addressed, little-endian instruction memory. It owns the fetch PC and reads one 32-bit word per cycle from the memory. Fetched {pc, instr} pairs are buffered in a small FIFO and delivered to decode over a valid/ready handshake. It also handles branch/jump redirects, flushes and fetch faults, so decode never drives the memory address directly.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- MEM_BYTES, 1024, instruction memory size in bytes; legal word addresses are 0..MEM_BYTES-4
- FIFO_DEPTH, 2, fetch buffer entries; must be a power of two and at least 2
- clk_i  input  1  single clock; all state updates on its rising edge
- rst_i  input  1  reset, synchronous, active-high
- mem_addr_o  output  32  byte address to instruction memory; always equals the fetch PC register
- mem_rdata_i  input  32  combinational read data returned for mem_addr_o in the same cycle
- redirect_i  input  1  flush the buffer and restart fetch
- redirect_pc_i  input  32  new fetch PC, sampled when redirect_i=1
- valid_o  output  1  FIFO head is valid
- ready_i  input  1  decode accepts the head this cycle
- instr_o  output  32  head instruction
- pc_o  output  32  head PC
- fault_o  output  1  head entry is a fetch fault; qualified by valid_o
- retired_cnt_o  output  32  delivered-instruction counter (see Configuration)
- stall_cnt_o  output  32  backpressure-cycle counter (see Configuration)

## Operation
- State registers:
  - fetch PC fpc (32 bits)
  - FIFO of FIFO_DEPTH entries, each {pc, instr, fault}
  - occupancy count (0..FIFO_DEPTH)
  - FSM with two states, RUN and HALT
- pop = valid_o & ready_i.
- push happens when all of the following hold: state is RUN, redirect_i=0, and (count<FIFO_DEPTH or pop).
  - A simultaneous push and pop while full is legal; count is unchanged.
- Push writes entry {fpc, mem_rdata_i, flt}.
  - flt = (fpc[1:0]!=0) | (fpc > MEM_BYTES-4).
  - When flt=1, the stored instr is 32'h0000_0000.
- After a push with flt=0, fpc <= fpc+4. The addition wraps modulo 2^32.
- After a push with flt=1, the FSM goes RUN->HALT and fpc holds. No pushes occur in HALT.
- Redirect (redirect_i=1):
  - Highest priority.
  - On the next edge: count <= 0, FIFO pointers reset, fpc <= redirect_pc_i, state <= RUN from either state.
  - A pop in the same cycle completes normally; decode keeps that instruction, and the remaining entries are discarded.
- Outputs:
  - valid_o = (count!=0).
  - instr_o, pc_o and fault_o show the head entry.
  - When count=0, instr_o, pc_o and fault_o are driven 0.
- Boundary cases:
  - Empty with ready_i=1: no pop.
  - Full with ready_i=0: fpc holds and mem_addr_o is stable.
  - Fault entry still buffered while a redirect arrives: the entry is dropped.

## Timing
- Reset values (rst_i=1 at an edge): fpc=RESET_PC, count=0, state=RUN, valid_o=0, instr_o=0, pc_o=0, fault_o=0, both counters 0.
- rst_i has priority over redirect_i.
- Fetch latency: data is captured at the same edge at which mem_addr_o is presented. The word is valid at the FIFO head one cycle after its address appears.
- First instruction after reset: with rst_i low at edge E1, the RESET_PC entry is pushed at E1, and valid_o=1 with pc_o=RESET_PC after E1.
- Throughput with ready_i held high: one instruction per cycle, PCs consecutive.
- Redirect penalty: redirect_i sampled at edge N gives valid_o=0 during cycle N+1. The target is pushed at N+1, and valid_o=1 with pc_o=target after N+1.
- No combinational path from ready_i or redirect_i to mem_addr_o.
- valid_o must not depend combinationally on ready_i.

## Configuration
- FETCH_PERF_CNT_EN is the only compile-time option.
- Defined:
  - retired_cnt_o increments on every pop with fault=0.
  - stall_cnt_o increments every cycle with valid_o=1 and ready_i=0.
  - Both counters wrap at 2^32 and clear on rst_i only; redirect_i does not clear them.
- Undefined: both ports are tied to 32'h0 and no counter flops are synthesized.

## Test plan
- Reset, then ready_i=1, memory filled with word value = address: pc_o/instr_o sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, valid_o continuous from the first edge after reset release.
- Hold ready_i=0 for 5 cycles after the first delivery: count reaches 2, mem_addr_o freezes at 0x8, then release ready_i: PCs 0x0, 0x4, 0x8 delivered with none lost or duplicated.
- Assert redirect_i for one cycle with redirect_pc_i=0x100 while the FIFO is full: one cycle of valid_o=0, then pc_o=0x100, then 0x104; stale 0x4/0x8 are never presented.
- Sequential fetch reaching 0x3FC (MEM_BYTES=1024): 0x3FC is delivered with fault_o=0. Next entry is pc 0x400 with fault_o=1 and instr_o=0. No further entries follow; mem_addr_o holds 0x400 until redirect_i with pc 0x0 resumes normal fetch.
- Redirect to 0x102 (misaligned): a single entry with fault_o=1 and pc_o=0x102, then HALT. Assert rst_i during HALT: all outputs return to their reset values, then fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN defined: deliver 10 instructions including 3 backpressure cycles → retired_cnt_o=10 and stall_cnt_o=3. Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port plus the decode-side valid/ready stream.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface instr_fetch_if;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic [31:0] retired_cnt_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output mem_addr_o,
    input  mem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output valid_o,
    input  ready_i,
    output instr_o,
    output pc_o,
    output fault_o,
    output retired_cnt_o,
    output stall_cnt_o
  );

  modport slave (
    input  mem_addr_o,
    output mem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  valid_o,
    output ready_i,
    input  instr_o,
    input  pc_o,
    input  fault_o,
    input  retired_cnt_o,
    input  stall_cnt_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with a small {pc, instr, fault} buffer toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_fetch_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]      LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state;
  logic [31:0]      fpc;
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic             fifo_fault [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic valid;
  logic pop;
  logic push;
  logic flt;

  assign valid = (count != '0);
  assign pop   = valid & bus.ready_i;
  assign flt   = (fpc[1:0] != 2'b00) | (fpc > LAST_WORD);
  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign push  = (state == RUN) & ~bus.redirect_i & ((count < FULL) | pop);

  assign bus.mem_addr_o = fpc;
  assign bus.valid_o    = valid;
  assign bus.instr_o    = valid ? fifo_instr[rd_ptr] : 32'h0;
  assign bus.pc_o       = valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign bus.fault_o    = valid ? fifo_fault[rd_ptr] : 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_i) begin
      state  <= RUN;
      fpc    <= bus.redirect_pc_i;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= fpc;
        fifo_instr[wr_ptr] <= flt ? 32'h0 : bus.mem_rdata_i;
        fifo_fault[wr_ptr] <= flt;
        wr_ptr             <= wr_ptr + 1'b1;
        if (flt) begin
          state <= HALT;
        end else begin
          fpc <= fpc + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  // Counters survive redirects; a pop in a redirect cycle still delivers its instruction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_cnt <= 32'h0;
      stall_cnt   <= 32'h0;
    end else begin
      if (pop && !fifo_fault[rd_ptr]) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (valid && !bus.ready_i) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign bus.retired_cnt_o = retired_cnt;
  assign bus.stall_cnt_o   = stall_cnt;
`else
  assign bus.retired_cnt_o = 32'h0;
  assign bus.stall_cnt_o   = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for streaming, backpressure,
// redirect, end-of-memory and misaligned faults, plus a perf-counter sequence.
module tb_instr_fetch_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks   = 0;
  int failures = 0;

  instr_fetch_if bus ();

  instr_fetch_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.master)
  );

  always #5 clk_i = ~clk_i;

  // Memory word at each address holds the address itself.
  assign bus.mem_rdata_i = bus.mem_addr_o;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redirect;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ef;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t mk(logic rst, logic ready, logic redirect, logic [31:0] rpc,
                              logic ev, logic [31:0] epc, logic [31:0] einstr,
                              logic ef, logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.ready = ready; v.redirect = redirect; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.ef = ef; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ready, input logic redirect,
                               input logic [31:0] rpc);
    rst_i             = rst;
    bus.ready_i       = ready;
    bus.redirect_i    = redirect;
    bus.redirect_pc_i = rpc;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_retired;
    logic [31:0] exp_stall;
    logic        pattern [13];

    bus.ready_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;

    // Reset, then streaming with ready held high
    vecs[0]  = mk(1, 1, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h4);
    vecs[2]  = mk(0, 1, 0, 32'h0,   1, 32'h4,   32'h4,   0, 32'h8);
    vecs[3]  = mk(0, 1, 0, 32'h0,   1, 32'h8,   32'h8,   0, 32'hC);
    vecs[4]  = mk(0, 1, 0, 32'h0,   1, 32'hC,   32'hC,   0, 32'h10);
    // Backpressure: fill to 2 entries, address freezes at 0x8
    vecs[5]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h4);
    vecs[7]  = mk(0, 0, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h8);
    vecs[8]  = mk(0, 0, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h8);
    vecs[9]  = mk(0, 0, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h8);
    vecs[10] = mk(0, 0, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h8);
    vecs[11] = mk(0, 1, 0, 32'h0,   1, 32'h4,   32'h4,   0, 32'hC);
    vecs[12] = mk(0, 1, 0, 32'h0,   1, 32'h8,   32'h8,   0, 32'h10);
    vecs[13] = mk(0, 1, 0, 32'h0,   1, 32'hC,   32'hC,   0, 32'h14);
    // Redirect while full: one empty cycle, then the target stream
    vecs[14] = mk(0, 0, 1, 32'h100, 0, 32'h0,   32'h0,   0, 32'h100);
    vecs[15] = mk(0, 1, 0, 32'h0,   1, 32'h100, 32'h100, 0, 32'h104);
    vecs[16] = mk(0, 1, 0, 32'h0,   1, 32'h104, 32'h104, 0, 32'h108);
    // Run off the end of memory
    vecs[17] = mk(0, 1, 1, 32'h3F8, 0, 32'h0,   32'h0,   0, 32'h3F8);
    vecs[18] = mk(0, 1, 0, 32'h0,   1, 32'h3F8, 32'h3F8, 0, 32'h3FC);
    vecs[19] = mk(0, 1, 0, 32'h0,   1, 32'h3FC, 32'h3FC, 0, 32'h400);
    vecs[20] = mk(0, 1, 0, 32'h0,   1, 32'h400, 32'h0,   1, 32'h400);
    vecs[21] = mk(0, 1, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h400);
    vecs[22] = mk(0, 1, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h400);
    vecs[23] = mk(0, 1, 1, 32'h0,   0, 32'h0,   32'h0,   0, 32'h0);
    vecs[24] = mk(0, 1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h4);
    // Misaligned target, then reset out of HALT
    vecs[25] = mk(0, 1, 1, 32'h102, 0, 32'h0,   32'h0,   0, 32'h102);
    vecs[26] = mk(0, 0, 0, 32'h0,   1, 32'h102, 32'h0,   1, 32'h102);
    vecs[27] = mk(0, 0, 0, 32'h0,   1, 32'h102, 32'h0,   1, 32'h102);
    vecs[28] = mk(1, 0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h0);
    vecs[29] = mk(0, 1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h4);
    // Reset wins over a simultaneous redirect
    vecs[30] = mk(1, 1, 1, 32'h200, 0, 32'h0,   32'h0,   0, 32'h0);
    vecs[31] = mk(0, 1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 32'h4);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].redirect, vecs[i].rpc);
      checkOutput($sformatf("v%0d valid", i), {31'h0, bus.valid_o}, {31'h0, vecs[i].ev});
      checkOutput($sformatf("v%0d pc",    i), bus.pc_o,    vecs[i].epc);
      checkOutput($sformatf("v%0d instr", i), bus.instr_o, vecs[i].einstr);
      checkOutput($sformatf("v%0d fault", i), {31'h0, bus.fault_o}, {31'h0, vecs[i].ef});
      checkOutput($sformatf("v%0d addr",  i), bus.mem_addr_o, vecs[i].eaddr);
`ifndef FETCH_PERF_CNT_EN
      checkOutput($sformatf("v%0d retired", i), bus.retired_cnt_o, 32'h0);
      checkOutput($sformatf("v%0d stall",   i), bus.stall_cnt_o,   32'h0);
`endif
    end

    // Counter sequence: 10 deliveries and 3 backpressure cycles after the first push
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("cnt reset retired", bus.retired_cnt_o, 32'h0);
    checkOutput("cnt reset stall",   bus.stall_cnt_o,   32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    pattern = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, pattern[i], 1'b0, 32'h0);
      checkOutput($sformatf("cnt valid c%0d", i), {31'h0, bus.valid_o}, 32'h1);
    end
`ifdef FETCH_PERF_CNT_EN
    exp_retired = 32'd10;
    exp_stall   = 32'd3;
`else
    exp_retired = 32'd0;
    exp_stall   = 32'd0;
`endif
    checkOutput("cnt retired", bus.retired_cnt_o, exp_retired);
    checkOutput("cnt stall",   bus.stall_cnt_o,   exp_stall);
    checkOutput("cnt head pc", bus.pc_o, 32'h28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
